// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic valid/ready pipeline register with synchronous flush.
// Define PIPE_SKID_EN for the two-entry skid variant with a registered in_ready.
module pipe_skid_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              r_main_v;
   logic [DATA_W-1:0] r_main_d;
   logic              w_main_v_nx;
   logic [DATA_W-1:0] w_main_d_nx;
   logic              w_acc;
   logic              w_drn;

   // Flush drops the offered input even when in_ready is high.
   assign w_acc     = in_valid & in_ready & ~flush;
   assign w_drn     = r_main_v & out_ready;
   assign out_valid = r_main_v;
   assign out_data  = r_main_d;

`ifdef PIPE_SKID_EN
   logic              r_skid_v;
   logic [DATA_W-1:0] r_skid_d;
   logic              w_skid_v_nx;
   logic [DATA_W-1:0] w_skid_d_nx;

   assign in_ready  = ~r_skid_v;
   assign occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};

   // Next main/skid contents; skid is only ever loaded while main is full.
   always_comb begin
      w_main_v_nx = r_main_v;
      w_main_d_nx = r_main_d;
      w_skid_v_nx = r_skid_v;
      w_skid_d_nx = r_skid_d;
      if (flush) begin
         w_main_v_nx = 1'b0;
         w_main_d_nx = '0;
         w_skid_v_nx = 1'b0;
         w_skid_d_nx = '0;
      end else if (!r_main_v) begin
         if (w_acc) begin
            w_main_v_nx = 1'b1;
            w_main_d_nx = in_data;
         end
      end else if (w_drn) begin
         if (r_skid_v) begin
            w_main_d_nx = r_skid_d;
            w_skid_v_nx = 1'b0;
            w_skid_d_nx = '0;
         end else if (w_acc) begin
            w_main_d_nx = in_data;
         end else begin
            w_main_v_nx = 1'b0;
            w_main_d_nx = '0;
         end
      end else if (w_acc) begin
         w_skid_v_nx = 1'b1;
         w_skid_d_nx = in_data;
      end
   end

   // Storage registers, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_v <= 1'b0;
         r_main_d <= '0;
         r_skid_v <= 1'b0;
         r_skid_d <= '0;
      end else begin
         r_main_v <= w_main_v_nx;
         r_main_d <= w_main_d_nx;
         r_skid_v <= w_skid_v_nx;
         r_skid_d <= w_skid_d_nx;
      end
   end
`else
   assign in_ready  = ~r_main_v | out_ready | flush;
   assign occupancy = {1'b0, r_main_v};

   // Single entry: accept replaces main, a lone drain empties it.
   always_comb begin
      w_main_v_nx = r_main_v;
      w_main_d_nx = r_main_d;
      if (flush) begin
         w_main_v_nx = 1'b0;
         w_main_d_nx = '0;
      end else if (w_acc) begin
         w_main_v_nx = 1'b1;
         w_main_d_nx = in_data;
      end else if (w_drn) begin
         w_main_v_nx = 1'b0;
         w_main_d_nx = '0;
      end
   end

   // Storage register, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_v <= 1'b0;
         r_main_d <= '0;
      end else begin
         r_main_v <= w_main_v_nx;
         r_main_d <= w_main_d_nx;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: vector table, directed corner cases and random traffic
// checked against a queue model of pipe_skid_reg.
module tb_pipe_skid_reg;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q[$];

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        eov;
      logic [31:0] eod;
      logic [1:0]  eocc;
      logic        eir;
   } vec_t;

   vec_t tbl[14];

   pipe_skid_reg #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic bit model_ir();
      if (SKID) return q.size() < 2;
      return (q.size() == 0) || out_ready || flush;
   endfunction

   task automatic chk_model(input string tag);
      int n;
      n = q.size();
      chk({tag, "_ov"}, 64'(out_valid), 64'(n > 0));
      chk({tag, "_od"}, 64'(out_data), (n > 0) ? 64'(q[0]) : 64'd0);
      chk({tag, "_occ"}, 64'(occupancy), 64'(n));
      chk({tag, "_ir"}, 64'(in_ready), 64'(model_ir()));
   endtask

   task automatic apply(input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   // Clock edge; the queue model follows the inputs held over that edge.
   task automatic advance();
      bit          fl;
      bit          drn;
      bit          acc;
      logic [31:0] d;
      fl  = flush;
      drn = (q.size() > 0) && out_ready;
      acc = in_valid && model_ir();
      d   = in_data;
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(d);
      end
   endtask

   initial begin
      logic [31:0] A, B, C, D, E, F;
      A = 32'hAAAA_5555;
      B = 32'h1234_5678;
      C = 32'h0000_00C1;
      D = 32'h0000_00D2;
      E = 32'h0000_00E3;
      F = 32'hFFFF_FFFF;

      tbl[0]  = '{1'b0, 1'b1, A, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[1]  = '{1'b0, 1'b1, B, 1'b0, 1'b1, A, 2'd1, SKID};
      tbl[2]  = '{1'b0, 1'b1, B, 1'b0, 1'b1, A,
                  SKID ? 2'd2 : 2'd1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, B, 1'b1, 1'b1, A,
                  SKID ? 2'd2 : 2'd1, !SKID};
      tbl[4]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, B, 2'd1, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, C, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, D, 1'b0, 1'b1, C, 2'd1, SKID};
      tbl[8]  = '{1'b1, 1'b1, F, 1'b0, 1'b1, C,
                  SKID ? 2'd2 : 2'd1, !SKID};
      tbl[9]  = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[11] = '{1'b0, 1'b1, E, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, E, 2'd1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #1;
      chk("rst0_ov", 64'(out_valid), 64'd0);
      chk("rst0_od", 64'(out_data), 64'd0);
      chk("rst0_occ", 64'(occupancy), 64'd0);
      chk("rst0_ir", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Backpressure, flush and drain-to-empty vectors.
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].eov));
         chk($sformatf("tbl%0d_od", i), 64'(out_data), 64'(tbl[i].eod));
         chk($sformatf("tbl%0d_occ", i), 64'(occupancy), 64'(tbl[i].eocc));
         chk($sformatf("tbl%0d_ir", i), 64'(in_ready), 64'(tbl[i].eir));
         advance();
      end

      // Back-to-back streaming, no bubbles.
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, i < 8, 32'h1111_0001 + 32'(i), 1'b1);
         chk_model("strm");
         if (i >= 1 && i <= 8) begin
            chk("strm_v", 64'(out_valid), 64'd1);
            chk("strm_d", 64'(out_data), 64'(32'h1111_0000 + 32'(i)));
         end
         advance();
      end

      // Asynchronous reset mid-stream with storage full.
      apply(1'b0, 1'b1, 32'h5151_0001, 1'b0);
      advance();
      apply(1'b0, 1'b1, 32'h5151_0002, 1'b0);
      advance();
      apply(1'b0, 1'b1, 32'h5151_0003, 1'b0);
      chk("full_occ", 64'(occupancy), SKID ? 64'd2 : 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rstm_ov", 64'(out_valid), 64'd0);
      chk("rstm_od", 64'(out_data), 64'd0);
      chk("rstm_occ", 64'(occupancy), 64'd0);
      chk("rstm_ir", 64'(in_ready), 64'd1);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(1'b0, 1'b1, 32'h7777_0001, 1'b1);
      chk_model("post_rst");
      advance();
      apply(1'b0, 1'b0, 32'd0, 1'b0);
      chk("first_acc", 64'(out_data), 64'h7777_0001);

      // Random traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         apply($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
               $urandom, $urandom_range(0, 3) != 0);
         chk_model($sformatf("rnd%0d", i));
         if (SKID == 1'b0)
            chk($sformatf("rnd%0d_max", i), 64'(occupancy <= 2'd1), 64'd1);
         advance();
      end

      apply(1'b0, 1'b0, 32'd0, 1'b1);
      repeat (3) advance();
      chk_model("end");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register that replaces the fixed stall/flush stage registers between pipeline stages (for example register-read to execute). It carries an opaque payload of configurable width using a valid/ready handshake on both sides. An optional skid entry keeps full throughput while cutting the combinational ready path. A synchronous flush squashes everything in flight.

## Interface
Parameters:
- DATA_W, 32, payload width in bits (packed pc, ctrl, dst_idx, sources, length, ...); legal range 1..1024

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream offers in_data
- in_ready  out  1  block can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  out_data holds a live entry
- out_ready  in  1  downstream consumes this cycle
- out_data  out  DATA_W  payload of oldest entry
- occupancy  out  2  number of live entries (0..2)

## Operation
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Storage is a main entry (drives out_data and out_valid) and a skid entry. The skid entry exists only with PIPE_SKID_EN.
- Skid behaviour, per cycle:
  - Main empty and accept: the input loads main.
  - Main full, drain and accept: skid empty loads the input into main; skid full moves skid to main.
  - Main full, no drain and accept: the input loads skid.
  - Drain and no accept: skid moves to main if valid, else main is emptied.
- in_ready = !skid_valid. It is a register output with no combinational path from out_ready.
- Data ordering is strict FIFO. No entry is duplicated or lost except by flush or reset.
- out_data is all-zero whenever out_valid=0. Any emptied entry has its data cleared to 0.
- occupancy = main_valid + skid_valid. Because skid is only loaded when main is full, occupancy=1 always means the main entry.
- Flush has the highest priority:
  - Next edge: both entries are invalid and zeroed, occupancy=0, in_ready=1.
  - Input offered in the flush cycle is dropped, even if in_ready=1. A drain in the flush cycle still counts as consumed by downstream.
- Reset (rst_n=0, any time, mid-transfer included):
  - Immediately: out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - All entries are cleared.
  - The first accept is possible on the first rising edge with rst_n=1.

## Timing
- Latency is 1 cycle. Data accepted at edge N is visible on out_data after edge N, when the block is empty.
- Throughput is 1 entry/cycle while out_ready=1.
- When out_ready drops with main full: one more input is absorbed into skid. in_ready falls after that edge.
- When out_ready rises with skid full: in_ready returns 1 after the next edge.
- in_ready does not depend on in_valid, and out_valid does not depend on out_ready. Upstream may drop in_valid at will.

## Configuration
- PIPE_SKID_EN defined: the two-entry behaviour above. in_ready is registered, occupancy ranges 0..2.
- PIPE_SKID_EN undefined:
  - Single entry only, and occupancy never exceeds 1.
  - in_ready = !out_valid | out_ready. This is combinational from out_ready, and is forced to 1 during flush.
  - Accept with drain replaces main in the same edge (1 entry/cycle sustained).
  - Flush, reset, zero-on-empty and latency rules are unchanged.

## Test plan
- Reset: hold rst_n=0 mid-stream with both entries full -> out_valid=0, out_data=0, occupancy=0, in_ready=1 immediately, before any clock edge.
- Streaming: out_ready=1; send 0x1111_0001..0x1111_0008 back-to-back -> the same eight values appear in order, 1 cycle later, with no bubbles.
- Backpressure (DATA_W=32, skid on):
  - Stimulus: send A=0xAAAA_5555, then out_ready=0, then send B=0x1234_5678.
  - Response: occupancy=2, in_ready=0, out_data holds A.
  - Stimulus: raise out_ready.
  - Response: A then B drained, in_ready=1 one edge later.
- Skid-off build: same stimulus -> B is held upstream (in_ready=0) until A drains. occupancy never exceeds 1.
- Flush:
  - Stimulus: with occupancy=2, assert flush while offering 0xFFFF_FFFF.
  - Response: next edge shows occupancy=0, out_valid=0, out_data=0, in_ready=1, and 0xFFFF_FFFF never appears.
- Drain to empty: out_ready=1 and in_valid=0 after one entry -> out_valid=0 and out_data=0 on the following cycle.
